dbg_host_bridge: RTL and testbench

// - Host-side debug link master: turns a byte stream from the host UART into b16 bus cycles.
// - Sits directly upstream of the debugger register block. Its bus writes at 0xFFE4
//   (breakpoint) and 0xFFE6 (run/step control) drive the debugger; its reads return core state.
// - Requests the bus from the arbiter, runs one word cycle per command and returns

---
 rtl/dbg_host_bridge_pkg.sv | 37 +++
 rtl/dbg_byte_shift.sv | 25 ++
 rtl/dbg_host_bridge.sv | 154 +++++++++++++++
 tb/tb_dbg_host_bridge.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbg_host_bridge_pkg.sv
// Shared definitions for the host debug bridge: opcodes, response codes,
// parser/bus state encoding and the debugger register byte addresses.
package dbg_host_bridge_pkg;

  localparam logic [1:0] OP_SYNC  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_BAD   = 2'b11;

  localparam logic [7:0] RSP_SYNC = 8'hA5;
  localparam logic [7:0] RSP_WACK = 8'h06;
  localparam logic [7:0] RSP_BAD  = 8'hEE;

  // Debugger register byte addresses (breakpoint, run/step control)
  localparam logic [15:0] DBG_REG_BP   = 16'hFFE4;
  localparam logic [15:0] DBG_REG_CTRL = 16'hFFE6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AH,
    ST_AL,
    ST_DH,
    ST_DL,
    ST_REQ,
    ST_BUS,
    ST_RDW,
    ST_TXH,
    ST_TXL,
    ST_TXA
  } state_t;

  // Single-byte response for commands that finish straight from IDLE
  function automatic logic [7:0] idle_resp(input logic [1:0] op);
    return (op == OP_SYNC) ? RSP_SYNC : RSP_BAD;
  endfunction

endpackage

// File: rtl/dbg_byte_shift.sv
// 16-bit word assembled from two independently loaded bytes (hi, lo).
module dbg_byte_shift (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_hi,
  input  logic        load_lo,
  input  logic [7:0]  din,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // Capture the incoming byte into the selected half
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      if (load_hi) r_q[15:8] <= din;
      if (load_lo) r_q[7:0]  <= din;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dbg_host_bridge.sv
// Host debug link master: parses UART command frames, runs one b16 word
// cycle per READ/WRITE command and returns the response bytes.
// The datapath is built for a 16-bit bus (l = 16).
module dbg_host_bridge
  import dbg_host_bridge_pkg::*;
#(
  parameter int l       = 16,
  parameter int TIMEOUT = 65535,
  parameter int TW      = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic         rx_ready,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         req,
  input  logic         gnt,
  output logic [l-1:1] addr,
  output logic [l-1:0] wdata,
  output logic         r,
  output logic [1:0]   w,
  input  logic [l-1:0] rdata
);

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [TW-1:0] r_cnt;
  logic [7:0]    r_tx_data;
  logic [7:0]    r_rd_lo;
  logic          r_rd;
  logic [1:0]    r_wr;

  logic          w_parse;
  logic          w_rx_xfer;
  logic          w_tx_xfer;
  logic          w_timeout;
  logic          w_grant_go;
  logic [15:0]   w_addr_word;
  logic [15:0]   w_wdata_word;
  logic          w_unused_addr0;

  assign w_parse   = (r_state == ST_AH) || (r_state == ST_AL) ||
                     (r_state == ST_DH) || (r_state == ST_DL);
  assign rx_ready  = (r_state == ST_IDLE) || w_parse;
  assign tx_valid  = (r_state == ST_TXH) || (r_state == ST_TXL) || (r_state == ST_TXA);
  assign req       = (r_state == ST_REQ) || (r_state == ST_BUS) || (r_state == ST_RDW);
  assign w_rx_xfer = rx_valid && rx_ready;
  assign w_tx_xfer = tx_valid && tx_ready;
  // A transfer in the same cycle wins over the timeout: the byte is kept
  assign w_timeout = w_parse && !w_rx_xfer && (r_cnt >= TW'(TIMEOUT));
  assign w_grant_go = (r_state == ST_REQ) && gnt;

  dbg_byte_shift u_addr (
    .clk     (clk),
    .reset   (reset),
    .load_hi ((r_state == ST_AH) && w_rx_xfer),
    .load_lo ((r_state == ST_AL) && w_rx_xfer),
    .din     (rx_data),
    .q       (w_addr_word)
  );

  dbg_byte_shift u_wdata (
    .clk     (clk),
    .reset   (reset),
    .load_hi ((r_state == ST_DH) && w_rx_xfer),
    .load_lo ((r_state == ST_DL) && w_rx_xfer),
    .din     (rx_data),
    .q       (w_wdata_word)
  );

  // The bus is word-addressed; the byte-select bit of addr_lo is dropped
  assign addr           = w_addr_word[15:1];
  assign w_unused_addr0 = w_addr_word[0];
  assign wdata          = w_wdata_word;
  assign r              = r_rd;
  assign w              = r_wr;
  assign tx_data        = r_tx_data;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode for the frame parser, bus cycle and response sender
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_rx_xfer)
                 w_next = ((rx_data[7:6] == OP_WRITE) || (rx_data[7:6] == OP_READ)) ? ST_AH : ST_TXA;
      ST_AH:   if (w_timeout) w_next = ST_IDLE;
               else if (w_rx_xfer) w_next = ST_AL;
      ST_AL:   if (w_timeout) w_next = ST_IDLE;
               else if (w_rx_xfer) w_next = (r_op == OP_WRITE) ? ST_DH : ST_REQ;
      ST_DH:   if (w_timeout) w_next = ST_IDLE;
               else if (w_rx_xfer) w_next = ST_DL;
      ST_DL:   if (w_timeout) w_next = ST_IDLE;
               else if (w_rx_xfer) w_next = ST_REQ;
      ST_REQ:  if (gnt) w_next = ST_BUS;
      ST_BUS:  w_next = (r_op == OP_WRITE) ? ST_TXA : ST_RDW;
      ST_RDW:  w_next = ST_TXH;
      ST_TXH:  if (tx_ready) w_next = ST_TXL;
      ST_TXL:  if (tx_ready) w_next = ST_IDLE;
      ST_TXA:  if (tx_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Latch the opcode of each command byte for the rest of the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   r_op <= OP_SYNC;
    else if ((r_state == ST_IDLE) && w_rx_xfer)  r_op <= rx_data[7:6];
  end

  // Inter-byte idle counter: runs only while mid-frame, saturates at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_cnt <= '0;
    else if (!w_parse || w_rx_xfer)  r_cnt <= '0;
    else if (r_cnt != {TW{1'b1}})    r_cnt <= r_cnt + 1'b1;
  end

  // One-cycle bus strobes, raised for the single BUS cycle after grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd <= 1'b0;
      r_wr <= 2'b00;
    end else begin
      r_rd <= w_grant_go && (r_op == OP_READ);
      r_wr <= (w_grant_go && (r_op == OP_WRITE)) ? 2'b11 : 2'b00;
    end
  end

  // Response byte register, loaded on entry to each TX state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_data <= 8'h00;
      r_rd_lo   <= 8'h00;
    end else if ((r_state == ST_IDLE) && (w_next == ST_TXA)) begin
      r_tx_data <= idle_resp(rx_data[7:6]);
    end else if ((r_state == ST_BUS) && (w_next == ST_TXA)) begin
      r_tx_data <= RSP_WACK;
    end else if (r_state == ST_RDW) begin
      r_tx_data <= rdata[15:8];
      r_rd_lo   <= rdata[7:0];
    end else if ((r_state == ST_TXH) && w_tx_xfer) begin
      r_tx_data <= r_rd_lo;
    end
  end

endmodule

// File: tb/tb_dbg_host_bridge.sv
// Scoreboard bench for dbg_host_bridge: frames are issued by a stimulus
// thread that pushes expected bus cycles and response bytes; a monitor
// thread pops and compares them whenever the DUT presents a strobe or byte.
module tb_dbg_host_bridge;
  import dbg_host_bridge_pkg::*;

  localparam int TB_TIMEOUT = 200;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        req;
  logic        gnt;
  logic [15:1] addr;
  logic [15:0] wdata;
  logic        r;
  logic [1:0]  w;
  logic [15:0] rdata;

  dbg_host_bridge #(.l(16), .TIMEOUT(TB_TIMEOUT), .TW(16)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .req(req), .gnt(gnt), .addr(addr), .wdata(wdata),
    .r(r), .w(w), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment: arbiter, transmitter, bus slave ----------------
  logic [1:0] tx_mode;   // 0 random, 1 held low, 2 held high
  logic       rnd_tx;
  logic       gnt_tie;
  logic       gnt_allow;
  logic       gnt_r;

  always @(posedge clk) rnd_tx <= ($urandom_range(0, 3) != 0);
  assign tx_ready = (tx_mode == 2'd0) ? rnd_tx : (tx_mode == 2'd2);

  always @(posedge clk or posedge reset)
    if (reset) gnt_r <= 1'b0;
    else       gnt_r <= req && (gnt_r || ($urandom_range(0, 2) == 0));
  assign gnt = gnt_tie | (gnt_allow & gnt_r);

  function automatic logic [15:0] init_val(input logic [14:0] a);
    if (a == 15'h091A) return 16'hBEEF;
    return {a[7:0] ^ 8'h3C, 1'b1, a[14:8]};
  endfunction

  logic [15:0] slave_mem [logic [14:0]];
  always @(posedge clk) begin
    if (w == 2'b11) slave_mem[addr] = wdata;
    if (r) rdata <= slave_mem.exists(addr) ? slave_mem[addr] : init_val(addr);
    else   rdata <= 16'($urandom);
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    bit          is_wr;
    logic [14:0] waddr;
    logic [15:0] data;
  } bus_t;

  bus_t        bus_q[$];
  logic [7:0]  tx_q[$];
  logic [15:0] model_mem [logic [14:0]];

  int n_cmp = 0;
  int n_fail = 0;
  int n_strobe = 0;
  int req_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Frame semantics from the command set, independent of DUT internals
  task automatic model_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] d);
    logic [14:0] wa;
    logic [15:0] v;
    wa = a[15:1];
    case (cmd[7:6])
      2'b00: tx_q.push_back(8'hA5);
      2'b01: begin
        bus_q.push_back('{1'b1, wa, d});
        model_mem[wa] = d;
        tx_q.push_back(8'h06);
      end
      2'b10: begin
        v = model_mem.exists(wa) ? model_mem[wa] : init_val(wa);
        bus_q.push_back('{1'b0, wa, 16'h0});
        tx_q.push_back(v[15:8]);
        tx_q.push_back(v[7:0]);
      end
      default: tx_q.push_back(8'hEE);
    endcase
  endtask

  task automatic monitor();
    logic       hold;
    logic [7:0] held;
    bus_t       e;
    hold = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
        continue;
      end
      if (req) req_cycles++;
      if (r || (w != 2'b00)) begin
        n_strobe++;
        if (bus_q.size() == 0) begin
          check("bus_unexpected", {61'b0, r, w}, 64'h0);
        end else begin
          e = bus_q.pop_front();
          check("bus_cycle",
                {29'b0, req, r, w, addr, (e.is_wr ? wdata : 16'h0)},
                {29'b0, 1'b1, ~e.is_wr, (e.is_wr ? 2'b11 : 2'b00), e.waddr, e.data});
        end
      end
      if (hold && tx_valid) check("tx_hold", {56'b0, tx_data}, {56'b0, held});
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) check("tx_unexpected", {56'b0, tx_data}, 64'h1_0000_0000);
        else                  check("tx_byte", {56'b0, tx_data}, {56'b0, tx_q.pop_front()});
      end
      hold = tx_valid && !tx_ready;
      held = tx_data;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    rx_valid = 1'b0;
    repeat (gap) step();
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail("rx_accept");
    step();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic issue_frame(input logic [7:0] cmd, input logic [15:0] a,
                             input logic [15:0] d, input int maxgap);
    model_frame(cmd, a, d);
    send_byte(cmd, $urandom_range(0, maxgap));
    if ((cmd[7:6] == 2'b01) || (cmd[7:6] == 2'b10)) begin
      send_byte(a[15:8], $urandom_range(0, maxgap));
      send_byte(a[7:0], $urandom_range(0, maxgap));
    end
    if (cmd[7:6] == 2'b01) begin
      send_byte(d[15:8], $urandom_range(0, maxgap));
      send_byte(d[7:0], $urandom_range(0, maxgap));
    end
  endtask

  task automatic wait_idle(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ((tx_q.size() == 0) && (bus_q.size() == 0) && !tx_valid && !req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) bound_fail(name);
    step();
  endtask

  task automatic measure_latency(input string name, input int exp);
    int lat;
    lat = 0;
    while (!tx_valid && (lat < 50)) begin
      step();
      lat++;
    end
    check(name, 64'(lat), 64'(exp));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, {63'b0, rx_ready}, 64'h1);
    check({tag, "_tx_valid"}, {63'b0, tx_valid}, 64'h0);
    check({tag, "_tx_data"},  {56'b0, tx_data},  64'h0);
    check({tag, "_req"},      {63'b0, req},      64'h0);
    check({tag, "_r"},        {63'b0, r},        64'h0);
    check({tag, "_w"},        {62'b0, w},        64'h0);
    check({tag, "_addr"},     {49'b0, addr},     64'h0);
    check({tag, "_wdata"},    {48'b0, wdata},    64'h0);
  endtask

  task automatic apply_reset_now(input string tag);
    reset = 1'b1;
    #1;
    check_reset_outputs(tag);
    tx_q.delete();
    bus_q.delete();
    step();
    step();
    check_reset_outputs({tag, "_held"});
    reset = 1'b0;
    step();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s0;
    int rq0;
    bit ok;
    logic [1:0]  op;
    logic [14:0] wa;

    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    tx_mode = 2'd2; gnt_tie = 1'b1; gnt_allow = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) step();
    check_reset_outputs("rst_init");
    reset = 1'b0;
    step();

    // SYNC: single response byte, no bus request
    rq0 = req_cycles;
    issue_frame(8'h00, 16'h0, 16'h0, 0);
    wait_idle("sync_done");
    check("sync_req_cycles", 64'(req_cycles - rq0), 64'h0);

    // WRITE to the breakpoint register
    issue_frame(8'h40, DBG_REG_BP, 16'h1234, 0);
    measure_latency("wr_latency", 2);
    wait_idle("write_done");

    // READ with known slave data 0xBEEF at word 0x091A
    issue_frame(8'h80, 16'h1235, 16'h0, 0);
    measure_latency("rd_latency", 3);
    wait_idle("read_done");

    // Unknown opcode: one 0xEE byte, then a SYNC proves we are back in IDLE
    issue_frame(8'hC7, 16'h0, 16'h0, 0);
    issue_frame(8'h3F, 16'h0, 16'h0, 0);
    wait_idle("bad_op_done");

    // Grant stall then transmitter backpressure
    gnt_tie = 1'b0; gnt_allow = 1'b0;
    s0 = n_strobe;
    issue_frame(8'h41, DBG_REG_CTRL, 16'h0003, 0);
    repeat (20) step();
    check("stall_req", {63'b0, req}, 64'h1);
    check("stall_no_strobe", 64'(n_strobe - s0), 64'h0);
    tx_mode = 2'd1;
    gnt_allow = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) bound_fail("stall_tx_valid");
    repeat (5) step();
    check("backpressure_valid", {63'b0, tx_valid}, 64'h1);
    tx_mode = 2'd2;
    wait_idle("stall_done");

    // Partial WRITE frame abandoned by the inter-byte timeout
    gnt_tie = 1'b1;
    s0 = n_strobe;
    send_byte(8'h40, 0);
    send_byte(8'hFF, 0);
    repeat (TB_TIMEOUT + 20) step();
    check("timeout_no_strobe", 64'(n_strobe - s0), 64'h0);
    check("timeout_no_tx", {63'b0, tx_valid}, 64'h0);
    issue_frame(8'h00, 16'h0, 16'h0, 0);
    wait_idle("timeout_sync_done");

    // Reset during the BUS cycle of a READ
    issue_frame(8'h80, 16'h1235, 16'h0, 0);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (r) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) bound_fail("reach_bus");
    apply_reset_now("rst_bus");

    // Reset while the low read byte is being offered
    tx_mode = 2'd1;
    issue_frame(8'h80, DBG_REG_BP, 16'h0, 0);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (tx_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) bound_fail("reach_txh");
    tx_mode = 2'd2;
    step();
    tx_mode = 2'd1;
    apply_reset_now("rst_txl");
    tx_mode = 2'd2;

    // Normal READ after reset returns the earlier breakpoint write
    issue_frame(8'h80, DBG_REG_BP, 16'h0, 0);
    wait_idle("post_reset_read");

    // Randomized frames with random gaps, grant delay and backpressure
    gnt_tie = 1'b0;
    tx_mode = 2'd0;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      wa = 15'h7FF0 + 15'($urandom_range(0, 15));
      issue_frame({op, 6'($urandom)}, {wa, 1'($urandom)}, 16'($urandom), 3);
    end
    wait_idle("random_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
